// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Frame layout: SYNC, ADDR, LEN, LEN data bytes, CSUM.
package loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StLen,
    StData,
    StCsum
  } state_e;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_CSUM    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  // A length byte of zero encodes a full 256-byte payload.
  function automatic logic [8:0] len_to_count(input logic [7:0] len);
    return (len == 8'd0) ? 9'd256 : {1'b0, len};
  endfunction

endpackage

// File: rtl/loader_timer.sv
// Inter-byte timeout counter: counts idle cycles while enabled, flags expiry
// once the count has reached TIMEOUT_CYCLES-1 without being cleared.
module loader_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt_q <= '0;
    end else if (enable && (cnt_q != CntMax)) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  // A byte arriving on the expiry cycle wins over the timeout.
  assign expire = enable && !clear && (cnt_q == CntMax);

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory writer: parses framed load packets from a byte stream,
// issues one registered write per data byte and releases the CPU on a good frame.
module imem_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned DATA_W         = 8,
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_w_en,
  output logic [ADDR_W-1:0] imem_w_addr,
  output logic [DATA_W-1:0] imem_w_data,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [1:0]        err_code
);

  state_e            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [7:0]        sum_q;
  logic [8:0]        remain_q;

  logic       accept;
  logic       timeout_expire;
  logic [7:0] csum_total;

  assign accept     = in_valid && in_ready;
  assign csum_total = sum_q + in_data;

  loader_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clear (accept || (state_q == StIdle)),
    .enable(state_q != StIdle),
    .expire(timeout_expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      sum_q       <= '0;
      remain_q    <= '0;
      in_ready    <= 1'b0;
      imem_w_en   <= 1'b0;
      imem_w_addr <= '0;
      imem_w_data <= '0;
      cpu_hold    <= 1'b1;
      load_done   <= 1'b0;
      load_err    <= 1'b0;
      err_code    <= ERR_NONE;
    end else begin
      in_ready  <= 1'b1;
      imem_w_en <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;

      if (timeout_expire) begin
        // Already-written bytes stay; the CPU remains held.
        state_q  <= StIdle;
        load_err <= 1'b1;
        err_code <= ERR_TIMEOUT;
      end else if (accept) begin
        case (state_q)
          StIdle: begin
            if (in_data == SYNC_BYTE) begin
              state_q  <= StAddr;
              cpu_hold <= 1'b1;
              err_code <= ERR_NONE;
            end
          end
          StAddr: begin
            ptr_q   <= ADDR_W'(in_data);
            sum_q   <= in_data;
            state_q <= StLen;
          end
          StLen: begin
            remain_q <= len_to_count(in_data);
            sum_q    <= sum_q + in_data;
            state_q  <= StData;
          end
          StData: begin
            imem_w_en   <= 1'b1;
            imem_w_addr <= ptr_q;
            imem_w_data <= DATA_W'(in_data);
            ptr_q       <= ptr_q + ADDR_W'(1);
            sum_q       <= sum_q + in_data;
            remain_q    <= remain_q - 9'd1;
            if (remain_q == 9'd1) begin
              state_q <= StCsum;
            end
          end
          StCsum: begin
            if (csum_total == 8'd0) begin
              load_done <= 1'b1;
              cpu_hold  <= 1'b0;
            end else begin
              load_err <= 1'b1;
              err_code <= ERR_CSUM;
            end
            state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule
